full_adder_32b_behavioural: RTL and testbench
=============================================

FULL_ADDER_32B_BEHAVIOURAL -- requirements
Module: full_adder_32b_behavioural

Interface
REQ-001 Parameter: WIDTH, 33, operand/sum width in bits (bits WIDTH-1:0).
REQ-002 Positional port order SHALL be: sum, c_out, a, b, c_in, clk, rst, overflow, zero.
REQ-003 clk  input  1  rising-edge clock; all state SHALL update on this edge only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sum  output  WIDTH  registered sum bits WIDTH-1:0.
REQ-006 c_out  output  1  registered unsigned carry out of bit WIDTH-1.
REQ-007 a  input  WIDTH  operand A, unsigned or two's-complement.
REQ-008 b  input  WIDTH  operand B, same encoding as A.
REQ-009 c_in  input  1  carry in, weight 1.
REQ-010 overflow  output  1  registered signed overflow flag.
REQ-011 zero  output  1  registered flag, high when registered sum is all zeros.

Function
REQ-012 Each rising clk edge with rst low SHALL capture {c_out, sum} = a + b + c_in, computed at WIDTH+1 bits with no truncation before the carry.
REQ-013 Latency SHALL be exactly 1 clock; inputs sampled at edge N appear on outputs after edge N and hold until edge N+1.
REQ-014 No handshake; a new result SHALL be produced every cycle (throughput 1/clock).
REQ-015 overflow SHALL equal (a[MSB] == b[MSB]) && (sum_next[MSB] != a[MSB]), registered with sum.
REQ-016 zero SHALL equal (sum_next == 0), registered with sum, independent of c_out.
REQ-017 All-ones + 0 + c_in=1 SHALL wrap: sum = 0, c_out = 1, zero = 1, overflow = 0.
REQ-018 All-ones + all-ones + 1 SHALL give sum = all-ones, c_out = 1.
REQ-019 Outputs SHALL be glitch-free: driven only from flops, with no combinational path from inputs to outputs.

Reset
REQ-020 rst high SHALL immediately force sum = 0, c_out = 0, overflow = 0, zero = 1, without waiting for clk.
REQ-021 While rst is high, outputs SHALL hold reset values regardless of clk and inputs.
REQ-022 On rst deassertion, the first result SHALL appear after the first rising clk edge with rst low.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight result; no stale value SHALL reappear after release.

Structure
REQ-024 WIDTH default (33) and reset values of sum, c_out, overflow and zero SHALL be constants in the shared adder package.
REQ-025 Addition SHALL be behavioural (single WIDTH+1-bit add), not a ripple of instantiated bit cells.
REQ-026 One sub-module, adder_flags_reg, SHALL hold the output register and flag derivation; the top SHALL hold the combinational add.

Verification
REQ-027 rst=1 with a=5, b=7, c_in=1 and clk toggling -> sum=0, c_out=0, overflow=0, zero=1 throughout.
REQ-028 a=0, b=0, c_in=0, then a=1 -> sum 0 then 1 one edge later; zero 1 then 0.
REQ-029 a=1, b=1, c_in=1 -> sum=3, c_out=0, overflow=0 after one edge.
REQ-030 a=0x1_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1, zero=1, overflow=0.
REQ-031 a=0x0_FFFF_FFFF, b=1, c_in=0 -> sum=0x1_0000_0000, c_out=0, overflow=1.
REQ-032 rst pulsed between edges with a non-zero result held -> outputs clear at once, without a clk edge, and recompute on the first edge after release.

Source files
------------

// File: rtl/full_adder_32b_behavioural_pkg.sv
// Shared constants and types for the registered behavioural adder.
package full_adder_32b_behavioural_pkg;

    // Default operand/sum width in bits.
    localparam int WIDTH_DEF = 33;

    // Reset values of the registered outputs.
    localparam logic RST_SUM_BIT  = 1'b0;
    localparam logic RST_C_OUT    = 1'b0;
    localparam logic RST_OVERFLOW = 1'b0;
    localparam logic RST_ZERO     = 1'b1;

    // Status flags registered alongside the sum.
    typedef struct packed {
        logic c_out;
        logic overflow;
        logic zero;
    } adder_flags_t;

    localparam adder_flags_t RST_FLAGS = '{
        c_out:    RST_C_OUT,
        overflow: RST_OVERFLOW,
        zero:     RST_ZERO
    };

endpackage

// File: rtl/full_adder_32b_behavioural_flags.sv
// Output register stage: derives carry/overflow/zero from the raw
// WIDTH+1-bit sum and holds everything in flops so the outputs never
// see a combinational path from the operands.
module adder_flags_reg
    import full_adder_32b_behavioural_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH:0]   sum_next_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             overflow_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] sum_d, sum_q;
    adder_flags_t     flags_d, flags_q;

    // Next-state: split carry from sum and derive signed overflow / zero.
    always_comb begin
        sum_d            = sum_next_i[WIDTH-1:0];
        flags_d.c_out    = sum_next_i[WIDTH];
        // Like-signed operands producing an opposite-signed result.
        flags_d.overflow = (a_msb_i == b_msb_i) && (sum_d[WIDTH-1] != a_msb_i);
        // Zero looks only at the sum bits; the carry is deliberately ignored.
        flags_d.zero     = (sum_d == '0);
    end

    // Result register; async reset clears in-flight data immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= {WIDTH{RST_SUM_BIT}};
            flags_q <= RST_FLAGS;
        end else begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    assign sum_o      = sum_q;
    assign c_out_o    = flags_q.c_out;
    assign overflow_o = flags_q.overflow;
    assign zero_o     = flags_q.zero;

endmodule

// File: rtl/full_adder_32b_behavioural.sv
// Registered WIDTH-bit adder with carry in/out, signed overflow and zero
// flags. One-cycle latency, a new result every clock.
module full_adder_32b_behavioural
    import full_adder_32b_behavioural_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             clk,
    input  logic             rst,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH:0] sum_next;

    // Single full-width add; operands are widened first so the carry survives.
    always_comb begin
        sum_next = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    end

    adder_flags_reg #(
        .WIDTH (WIDTH)
    ) u_flags_reg (
        .clk        (clk),
        .rst        (rst),
        .sum_next_i (sum_next),
        .a_msb_i    (a[WIDTH-1]),
        .b_msb_i    (b[WIDTH-1]),
        .sum_o      (sum),
        .c_out_o    (c_out),
        .overflow_o (overflow),
        .zero_o     (zero)
    );

endmodule

// File: tb/tb_full_adder_32b_behavioural.sv
// Directed bench for the registered 33-bit adder.
module tb_full_adder_32b_behavioural;

    localparam int W = 33;

    logic [W-1:0] sum, a, b;
    logic         c_out, c_in, clk, rst, overflow, zero;

    int n_vec = 0;
    int n_err = 0;

    full_adder_32b_behavioural dut (
        .sum      (sum),
        .c_out    (c_out),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .clk      (clk),
        .rst      (rst),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all four registered outputs.
    task automatic chk_all(input string tag, input logic [W-1:0] e_sum,
                           input logic e_c, input logic e_ov, input logic e_z);
        chk({tag, ".sum"},      64'(sum),      64'(e_sum));
        chk({tag, ".c_out"},    64'(c_out),    64'(e_c));
        chk({tag, ".overflow"}, 64'(overflow), 64'(e_ov));
        chk({tag, ".zero"},     64'(zero),     64'(e_z));
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with non-zero operands: outputs stay cleared.
        rst = 1'b1; a = 33'd5; b = 33'd7; c_in = 1'b1;
        #1;
        chk_all("rst_async", 33'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("rst_hold", 33'd0, 1'b0, 1'b0, 1'b1);
        end

        // Release, zero operands: first result after first edge.
        a = 33'd0; b = 33'd0; c_in = 1'b0;
        rst = 1'b0;
        #1;
        chk_all("rel_pre_edge", 33'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("zero_add", 33'd0, 1'b0, 1'b0, 1'b1);

        // a=1: sum still 0 until the edge, then 1.
        a = 33'd1;
        #1;
        chk_all("latency_pre", 33'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("one_add", 33'd1, 1'b0, 1'b0, 1'b0);

        // 1 + 1 + 1 = 3.
        a = 33'd1; b = 33'd1; c_in = 1'b1;
        step();
        chk_all("one_one_cin", 33'd3, 1'b0, 1'b0, 1'b0);

        // All-ones + 0 + 1 wraps to zero with carry.
        a = 33'h1_FFFF_FFFF; b = 33'd0; c_in = 1'b1;
        step();
        chk_all("wrap", 33'd0, 1'b1, 1'b0, 1'b1);

        // Positive + positive crossing into the sign bit.
        a = 33'h0_FFFF_FFFF; b = 33'd1; c_in = 1'b0;
        step();
        chk_all("pos_ovf", 33'h1_0000_0000, 1'b0, 1'b1, 1'b0);

        // All-ones + all-ones + 1.
        a = 33'h1_FFFF_FFFF; b = 33'h1_FFFF_FFFF; c_in = 1'b1;
        step();
        chk_all("ones_ones_cin", 33'h1_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Most-negative + most-negative: zero sum with carry and overflow.
        a = 33'h1_0000_0000; b = 33'h1_0000_0000; c_in = 1'b0;
        step();
        chk_all("neg_ovf_zero", 33'd0, 1'b1, 1'b1, 1'b1);

        // Mixed signs never overflow: -1 + 5 = 4.
        a = 33'h1_FFFF_FFFF; b = 33'd5; c_in = 1'b0;
        step();
        chk_all("mixed_sign", 33'd4, 1'b1, 1'b0, 1'b0);

        // Back-to-back results, one per clock.
        a = 33'h0_1234_5678; b = 33'h0_1111_1111; c_in = 1'b0;
        step();
        chk_all("stream0", 33'h0_2345_6789, 1'b0, 1'b0, 1'b0);
        a = 33'h0_8000_0000; b = 33'h0_8000_0000; c_in = 1'b1;
        step();
        chk_all("stream1", 33'h1_0000_0001, 1'b0, 1'b1, 1'b0);

        // Reset pulse between edges with a non-zero result held.
        a = 33'd3; b = 33'd4; c_in = 1'b0;
        step();
        chk_all("pre_pulse", 33'd7, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("pulse_clear", 33'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk_all("pulse_no_stale", 33'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("pulse_recompute", 33'd7, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
